// File: rtl/alu_pkg.sv
// alu_pkg: mode codes, FSM state encoding and helpers shared by the ALU operand conditioners
package alu_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Most negative two's-complement value of a w-bit word, right-aligned in 64 bits
  function automatic logic [63:0] most_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/inv_add_slice.sv
// inv_add_slice: conditional inverter plus incrementer for one CHUNK-bit slice
module inv_add_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] slice_i,
  input  logic             inv_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  // Invert when asked, then add the chained carry; the extra bit is the carry-out
  always_comb begin
    {cout_o, sum_o} = {1'b0, slice_i ^ {CHUNK{inv_i}}} + {{CHUNK{1'b0}}, cin_i};
  end

endmodule

// File: rtl/inv_neg_serial.sv
// inv_neg_serial: chunk-serial pass/invert/negate/abs of a WIDTH-bit operand with result flags
module inv_neg_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);
  import alu_pkg::*;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [63:0] MN64 = most_neg(WIDTH);
  localparam logic [WIDTH-1:0] MN = MN64[WIDTH-1:0];

  if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("inv_neg_serial: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             inv_q, inv_d;
  logic             ovfp_q, ovfp_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK-1:0] sl, sum;
  logic             cout;

  assign sl = a_q[idx_q*CHUNK +: CHUNK];

  inv_add_slice #(.CHUNK(CHUNK)) u_slice (
    .slice_i(sl),
    .inv_i  (inv_q),
    .cin_i  (carry_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Next state: accept in IDLE, one chunk per BUSY cycle, wait for the consumer in DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    ovfp_d  = ovfp_q;
    a_d     = a_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    if (state_q == ST_IDLE && in_valid) begin
      state_d = ST_BUSY;
      a_d     = a;
      idx_d   = '0;
      inv_d   = (mode == MODE_INV) | (mode == MODE_NEG) | ((mode == MODE_ABS) & a[WIDTH-1]);
      carry_d = (mode == MODE_NEG) | ((mode == MODE_ABS) & a[WIDTH-1]);
      ovfp_d  = ((mode == MODE_NEG) | (mode == MODE_ABS)) & (a == MN);
    end
    if (state_q == ST_BUSY) begin
      res_d[idx_q*CHUNK +: CHUNK] = sum;
      carry_d = cout;
      idx_d   = idx_q + 1'b1;
      if (idx_q == IW'(NCHUNK - 1)) begin
        state_d = ST_DONE;
        zero_d  = (res_d == '0);
        neg_d   = res_d[WIDTH-1];
        ovf_d   = ovfp_q;
      end
    end
    if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      ovfp_q  <= 1'b0;
      a_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      ovfp_q  <= ovfp_d;
      a_q     <= a_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign q         = res_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_inv_neg_serial.sv
// tb_inv_neg_serial: scoreboard bench for inv_neg_serial against an arithmetic reference model
module tb_inv_neg_serial;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  typedef struct {
    logic [W-1:0] q;
    logic         z;
    logic         n;
    logic         o;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_s;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic         busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  inv_neg_serial #(.WIDTH(W), .CHUNK(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_s),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input logic [W-1:0] av, input logic [1:0] m);
    exp_t e;
    logic [W-1:0] mn;
    logic signed [W-1:0] sv;
    mn = {1'b1, {(W-1){1'b0}}};
    sv = av;
    case (m)
      2'b00:   e.q = av;
      2'b01:   e.q = ~av;
      2'b10:   e.q = W'(0 - av);
      default: e.q = (sv < 0) ? W'(0 - av) : av;
    endcase
    e.z = (e.q == 0);
    e.n = e.q[W-1];
    e.o = m[1] && (av == mn);
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [1:0] m);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    a_s = av;
    mode = m;
    in_valid = 1'b1;
    e = model(av, m);
    e.acc = cyc + 1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    a_s = W'($urandom);
    mode = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || busy) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic monitor();
    exp_t h;
    logic seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        sb.delete();
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got q=%h want no result", q);
            h.q = q; h.z = zero; h.n = neg; h.o = ovf; h.acc = cyc - NC;
          end else begin
            h = sb.pop_front();
            chk("latency", W'(cyc - h.acc), W'(NC));
            chk("q", q, h.q);
            chk("zero", W'(zero), W'(h.z));
            chk("neg", W'(neg), W'(h.n));
            chk("ovf", W'(ovf), W'(h.o));
          end
        end else begin
          chk("hold_q", q, h.q);
          chk("hold_flags", W'({zero, neg, ovf}), W'({h.z, h.n, h.o}));
        end
        if (out_ready) seen = 1'b0;
      end
    end
  endtask

  initial begin
    logic [W-1:0] mn;
    logic [W-1:0] nv;
    exp_t e;
    int n;
    mn = {1'b1, {(W-1){1'b0}}};
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_s = '0;
    mode = 2'b00;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_q", q, W'(0));
    chk("rst_flags", W'({zero, neg, ovf}), W'(0));
    rst_n = 1'b1;
    tick();

    send(W'(16'h1234), 2'b00);
    send(W'(16'h00FF), 2'b01);
    send(W'(16'h0001), 2'b10);
    send(W'(16'h0000), 2'b10);
    send(W'(16'hFFF6), 2'b11);
    send(mn, 2'b10);
    send(mn, 2'b11);
    send(W'(16'h0007), 2'b11);
    drain();
    repeat (3) tick();
    chk("idle_hold_q", q, W'(16'h0007));
    chk("idle_hold_flags", W'({zero, neg, ovf}), W'(0));

    out_ready = 1'b0;
    send(W'(16'h4321), 2'b10);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_out_valid", W'(out_valid), W'(1));
    nv = W'(16'h0F0F);
    a_s = nv;
    mode = 2'b01;
    in_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_out_valid_hold", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_in_ready", W'(in_ready), W'(1));
    chk("bp_idle_out_valid", W'(out_valid), W'(0));
    e = model(nv, 2'b01);
    e.acc = cyc + 1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    chk("bp_accepted_busy", W'(busy), W'(1));
    drain();

    send(W'(16'hBEEF), 2'b10);
    repeat ((NC > 2) ? 2 : NC - 1) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_q", q, W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    tick();
    rst_n = 1'b1;
    tick();
    send(W'(16'h0005), 2'b10);
    drain();

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      case ($urandom_range(0, 5))
        0:       send(mn, 2'($urandom));
        1:       send('0, 2'($urandom));
        default: send(W'($urandom), 2'($urandom));
      endcase
    end
    drain();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
